// File: rtl/controle_acesso_pkg.sv
// rtl/controle_acesso_pkg.sv - shared FSM encodings, resource constants and helpers
package controle_acesso_pkg;

    // Encodings are shared with the authentication stage; keep values stable.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_GRANT   = 3'd2,
        ST_DENY    = 3'd3,
        ST_LOCKOUT = 3'd4
    } estado_t;

    localparam logic [2:0] SEL_INVALID = 3'd7;
    localparam int         NUM_RES     = 7;
    localparam int         CNT_W       = 8;

    // One-hot open command for a resource index; the invalid index maps to all-zero.
    function automatic logic [NUM_RES-1:0] sel_onehot(input logic [2:0] sel);
        logic [7:0] oh;
        oh = 8'b1 << sel;
        return oh[NUM_RES-1:0];
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/controle_acesso_if.sv
// rtl/controle_acesso_if.sv - request/permission/result bundle (audit ports with ACESSO_AUDIT_EN)
interface controle_acesso_if;
    import controle_acesso_pkg::*;

    logic [NUM_RES-1:0] perm;
    logic               req_valid;
    logic [2:0]         req_sel;
    logic               req_ready;
    logic [NUM_RES-1:0] unlock;
    logic               denied;
    logic               locked;

`ifdef ACESSO_AUDIT_EN
    logic [CNT_W-1:0]   grant_cnt;
    logic [CNT_W-1:0]   deny_cnt;

    modport slave (
        input  perm, req_valid, req_sel,
        output req_ready, unlock, denied, locked, grant_cnt, deny_cnt
    );
    modport master (
        output perm, req_valid, req_sel,
        input  req_ready, unlock, denied, locked, grant_cnt, deny_cnt
    );
`else
    modport slave (
        input  perm, req_valid, req_sel,
        output req_ready, unlock, denied, locked
    );
    modport master (
        output perm, req_valid, req_sel,
        input  req_ready, unlock, denied, locked
    );
`endif

endinterface

// File: rtl/controle_acesso_contador_tempo.sv
// rtl/controle_acesso_contador_tempo.sv - loadable down-counter with done flag
module contador_tempo #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load takes priority; otherwise count down while enabled, parking at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Done on the last counted cycle, so a load of N gives exactly N cycles.
    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/controle_acesso.sv
// rtl/controle_acesso.sv - access controller FSM with timed unlock and lockout; audit counters with ACESSO_AUDIT_EN
module controle_acesso
    import controle_acesso_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    controle_acesso_if.slave   bus
);

    localparam int TW = $clog2(max_int(HOLD_CYCLES, LOCK_CYCLES) + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] LOCK_LD = TW'(LOCK_CYCLES);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);

    estado_t            state_q;
    estado_t            state_d;
    logic [2:0]         sel_q;
    logic               ok_q;
    logic [FW-1:0]      fail_q;
    logic [FW-1:0]      fail_d;
    logic               req_ready_q;
    logic               accept;
    logic               tmr_load;
    logic [TW-1:0]      tmr_val;
    logic               tmr_en;
    logic               tmr_done;
    logic [NUM_RES-1:0] unlock;
    logic               denied;
    logic               locked;
    logic [7:0]         perm_ext;

    assign accept   = bus.req_valid && req_ready_q;
    // Index 7 lands on the padded zero, so the invalid selector can never grant.
    assign perm_ext = {1'b0, bus.perm};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the deny count compared here is already incremented.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept)   state_d = ST_CHECK;
            ST_CHECK:   state_d = ok_q ? ST_GRANT : ST_DENY;
            ST_GRANT:   if (tmr_done) state_d = ST_IDLE;
            ST_DENY:    state_d = (fail_q == FAIL_MAX) ? ST_LOCKOUT : ST_IDLE;
            ST_LOCKOUT: if (tmr_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        unlock = '0;
        denied = 1'b0;
        locked = 1'b0;
        case (state_q)
            ST_GRANT:   unlock = sel_onehot(sel_q);
            ST_DENY:    denied = 1'b1;
            ST_LOCKOUT: locked = 1'b1;
            default:    ;
        endcase
    end

    // Capture selector and permission bit at accept; later perm changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= SEL_INVALID;
            ok_q  <= 1'b0;
        end else if (accept) begin
            sel_q <= bus.req_sel;
            ok_q  <= (bus.req_sel != SEL_INVALID) && perm_ext[bus.req_sel];
        end
    end

    // Fail counter: cleared on grant and lockout exit, saturating increment on deny.
    always_comb begin
        fail_d = fail_q;
        if (state_q == ST_CHECK) begin
            if (ok_q) begin
                fail_d = '0;
            end else if (fail_q != FAIL_MAX) begin
                fail_d = fail_q + FW'(1);
            end
        end else if ((state_q == ST_LOCKOUT) && tmr_done) begin
            fail_d = '0;
        end
    end

    // Fail counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_q <= '0;
        end else begin
            fail_q <= fail_d;
        end
    end

    // Ready follows the upcoming state so it is high exactly while in IDLE and low in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q <= 1'b0;
        end else begin
            req_ready_q <= (state_d == ST_IDLE);
        end
    end

    assign tmr_load = ((state_q == ST_CHECK) && ok_q) ||
                      ((state_q == ST_DENY) && (fail_q == FAIL_MAX));
    assign tmr_val  = (state_q == ST_CHECK) ? HOLD_LD : LOCK_LD;
    assign tmr_en   = (state_q == ST_GRANT) || (state_q == ST_LOCKOUT);

    contador_tempo #(
        .W (TW)
    ) u_tempo (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .done_o     (tmr_done)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.unlock    = unlock;
    assign bus.denied    = denied;
    assign bus.locked    = locked;

`ifdef ACESSO_AUDIT_EN
    logic [CNT_W-1:0] grant_cnt_q;
    logic [CNT_W-1:0] deny_cnt_q;

    // Audit counters bump on GRANT/DENY entry and wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            deny_cnt_q  <= '0;
        end else if (state_q == ST_CHECK) begin
            if (ok_q) begin
                grant_cnt_q <= grant_cnt_q + CNT_W'(1);
            end else begin
                deny_cnt_q  <= deny_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.grant_cnt = grant_cnt_q;
    assign bus.deny_cnt  = deny_cnt_q;
`endif

endmodule
